// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO, with configurable frame format and CTS gating.
// All tx changes land on divider ticks; a non-empty FIFO yields back-to-back frames.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CTS_EN     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_BITS-1:0]             data,
  input  logic                             data_valid,
  output logic                             data_ready,
  input  logic                             cts,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             tx_done
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [DW-1:0]        div_cnt;
  logic                 bit_tick;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop, fifo_empty, can_start;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bit, par_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 tx_nxt, busy_nxt, done_nxt;

  assign bit_tick = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        div_cnt <= '0;
    else if (bit_tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + DW'(1);
  end

  assign data_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign push       = data_valid & data_ready;
  assign can_start  = !fifo_empty && (cts || (CTS_EN == 0));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_level <= fifo_level + LW'(1);
      else if (pop && !push) fifo_level <= fifo_level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      shreg   <= '0;
      par_bit <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
      tx_done <= done_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Loading a frame (from IDLE or straight out of the last stop bit) pops the FIFO head.
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    if (bit_tick) begin
      unique case (state)
        S_IDLE: begin
          if (can_start) begin
            pop       = 1'b1;
            state_nxt = S_START;
            tx_nxt    = 1'b0;
            busy_nxt  = 1'b1;
            shreg_nxt = mem[rd_ptr];
            par_nxt   = (^mem[rd_ptr]) ^ (PARITY == 1);
          end
        end
        S_START: begin
          state_nxt = S_DATA;
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
          cnt_nxt   = '0;
        end
        S_DATA: begin
          if (cnt == CW'(DATA_BITS - 1)) begin
            cnt_nxt = '0;
            if (PARITY != 0) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
            cnt_nxt   = cnt + CW'(1);
          end
        end
        S_PARITY: begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
          cnt_nxt   = '0;
        end
        S_STOP: begin
          if (cnt == CW'(STOP_BITS - 1)) begin
            done_nxt = 1'b1;
            cnt_nxt  = '0;
            if (can_start) begin
              pop       = 1'b1;
              state_nxt = S_START;
              tx_nxt    = 1'b0;
              shreg_nxt = mem[rd_ptr];
              par_nxt   = (^mem[rd_ptr]) ^ (PARITY == 1);
            end else begin
              state_nxt = S_IDLE;
              busy_nxt  = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame monitor checks every serial frame against a byte queue model.
module tb_uart_tx_fifo;
  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data;
  logic       data_valid, data_ready, cts, tx, busy, tx_done;
  logic [2:0] fifo_level;
  logic [6:0] data6;
  logic       valid6, ready6, tx6, busy6, done6;
  logic [2:0] level6;

  int errors = 0, checks = 0;
  int cyc = 0, rel_cyc = 0, last_push_cyc = 0;
  int frames_done = 0, frames_started = 0;
  int starts[$];
  int levels[$];
  logic [7:0] model_q[$];
  logic [10:0] last_bits;
  bit mon_en = 1'b1;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                 .FIFO_DEPTH(4), .CTS_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .cts(cts), .tx(tx), .busy(busy),
    .fifo_level(fifo_level), .tx_done(tx_done));

  uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                 .FIFO_DEPTH(4), .CTS_EN(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .data(data6), .data_valid(valid6),
    .data_ready(ready6), .cts(1'b1), .tx(tx6), .busy(busy6),
    .fifo_level(level6), .tx_done(done6));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected line levels of one frame, bit 0 = start bit.
  function automatic int build_frame(input logic [8:0] d, input int nb, input int par,
                                     input int sb, output logic [15:0] bits);
    int n, ones;
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (par != 0) begin
      bits[n] = ((ones % 2) == 1) ? (par == 2) : (par == 1);
      n++;
    end
    return n + sb;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && data_valid && data_ready) begin
      model_q.push_back(data);
      last_push_cyc <= cyc + 1;
    end
  end

  always @(negedge rst_n) model_q.delete();

  task automatic do_frame();
    logic [7:0]  d;
    logic [15:0] bits;
    logic [15:0] seen;
    int len, dn, nbusy;
    dn = 0;
    nbusy = 0;
    seen = '1;
    frames_started++;
    starts.push_back(cyc);
    if (model_q.size() == 0) begin
      chk("spurious_frame", 1, 0);
      d = 8'h00;
    end else begin
      d = model_q.pop_front();
    end
    levels.push_back(int'(fifo_level));
    chk("level_at_start", fifo_level, model_q.size());
    chk("tick_align", (cyc - rel_cyc) % CD, 0);
    len = build_frame({1'b0, d}, 8, 2, 1, bits);
    for (int b = 0; b < len; b++) begin
      logic got;
      got = bits[b];
      for (int c = 0; c < CD; c++) begin
        if (b != 0 || c != 0) begin
          @(negedge clk);
          if (tx_done === 1'b1) dn++;
        end
        if (tx !== bits[b]) got = tx;
        if (busy !== 1'b1) nbusy++;
      end
      seen[b] = got;
      chk($sformatf("frame_bit%0d", b), got, bits[b]);
    end
    chk("busy_in_frame", nbusy, 0);
    @(negedge clk);
    chk("tx_done_end", tx_done, 1);
    chk("tx_done_extra", dn, 0);
    chk("busy_end", busy, (tx === 1'b0));
    last_bits = seen[10:0];
    frames_done++;
  endtask

  initial begin
    @(negedge clk);
    forever begin
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) do_frame();
      else @(negedge clk);
    end
  end

  task automatic push_one(input logic [7:0] d);
    int n;
    n = 0;
    data = d;
    data_valid = 1'b1;
    while (!data_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("push_timeout", 0, 1);
    @(negedge clk);
    data_valid = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_wait", frames_done >= n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, s0, lows, dones, bad, t, c, expt, len6, st6;
    logic rdy[6];
    logic [15:0] bits6, seen6;

    data = 8'h00; data_valid = 1'b0; cts = 1'b0; data6 = '0; valid6 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_done", tx_done, 0);
    rst_n = 1'b1;
    rel_cyc = cyc;
    lows = 0; dones = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    chk("idle_tx_low", lows, 0);
    chk("idle_done", dones, 0);
    chk("idle_ready", data_ready, 1);

    // single byte, even parity
    cts = 1'b1;
    f0 = frames_done;
    push_one(8'hA5);
    wait_frames(f0 + 1);
    chk("a5_bits", last_bits, 11'h54A);
    chk("a5_latency", (starts[$] - last_push_cyc) inside {[1:CD+1]}, 1);
    @(negedge clk);
    chk("a5_busy_after", busy, 0);

    // fill with cts low, then drain back-to-back
    cts = 1'b0;
    f0 = frames_done;
    s0 = starts.size();
    for (int i = 1; i <= 5; i++) begin
      data = 8'(i);
      data_valid = 1'b1;
      @(negedge clk);
      rdy[i] = data_ready;
    end
    data_valid = 1'b0;
    chk("fill_ready_after3", rdy[3], 1);
    chk("fill_ready_after4", rdy[4], 0);
    chk("fill_level", fifo_level, 4);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("cts_hold_tx", lows, 0);
    cts = 1'b1;
    wait_frames(f0 + 4);
    for (int k = 0; k < 3; k++) chk($sformatf("b2b_gap%0d", k), starts[s0+k+1] - starts[s0+k], 44);
    for (int k = 0; k < 4; k++) chk($sformatf("b2b_level%0d", k), levels[s0+k], 3 - k);
    repeat (60) @(negedge clk);
    chk("fifth_not_sent", frames_done, f0 + 4);

    // cts dropped mid-frame
    f0 = frames_done;
    s0 = starts.size();
    push_one(8'h3C);
    push_one(8'hC3);
    push_one(8'h96);
    t = 0;
    while (starts.size() == s0 && t < 100) begin @(negedge clk); t++; end
    chk("cts_frame1_start", starts.size(), s0 + 1);
    while (cyc - starts[s0] < 22 && t < 200) begin @(negedge clk); t++; end
    chk("cts_drop_level", fifo_level, 2);
    cts = 1'b0;
    wait_frames(f0 + 1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("cts_paused", bad, 0);
    chk("cts_no_start", starts.size(), s0 + 1);
    cts = 1'b1;
    c = cyc;
    expt = c + 1 + ((CD - ((c + 1 - rel_cyc) % CD)) % CD);
    wait_frames(f0 + 2);
    chk("cts_resume", starts[s0+1], expt);
    wait_frames(f0 + 3);

    // random traffic with random cts
    f0 = frames_done;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      cts = ($urandom_range(0, 3) != 0);
      if (!data_ready) cts = 1'b1;
      push_one(8'($urandom));
    end
    cts = 1'b1;
    wait_frames(f0 + 24);
    chk("rand_drain", model_q.size(), 0);
    repeat (10) @(negedge clk);
    chk("rand_idle_busy", busy, 0);

    // reset in the middle of data bit 3
    mon_en = 1'b0;
    cts = 1'b0;
    push_one(8'h00);
    push_one(8'h5A);
    push_one(8'h77);
    cts = 1'b1;
    t = 0;
    while (tx !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    chk("rst_frame_start", tx, 0);
    repeat (17) @(negedge clk);
    chk("mid_bit3", tx, 0);
    chk("mid_level", fifo_level, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", tx, 1);
    chk("async_level", fifo_level, 0);
    chk("async_busy", busy, 0);
    chk("async_done", tx_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    lows = 0; dones = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    chk("post_rst_tx", lows, 0);
    chk("post_rst_done", dones, 0);
    chk("post_rst_level", fifo_level, 0);
    mon_en = 1'b1;

    // 7 data bits, odd parity, two stop bits, 3 clocks per bit
    data6 = 7'h00;
    valid6 = 1'b1;
    @(negedge clk);
    valid6 = 1'b0;
    t = 0;
    while (tx6 !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    chk("f6_start", tx6, 0);
    st6 = cyc;
    len6 = build_frame(9'h000, 7, 1, 2, bits6);
    seen6 = '1;
    for (int b = 0; b < len6; b++) begin
      logic got;
      got = bits6[b];
      for (int k = 0; k < 3; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        if (tx6 !== bits6[b]) got = tx6;
      end
      seen6[b] = got;
    end
    chk("f6_bits", seen6[10:0], 11'h700);
    @(negedge clk);
    chk("f6_done", done6, 1);
    chk("f6_len", cyc - st6, 33);
    chk("f6_busy", busy6, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
